lsu_controller: RTL and testbench

Multi-cycle load/store sequencer between the core datapath and a handshaked data-memory port. On a memory instruction it stalls the core, issues one word-aligned bus request with byte enables, waits for read data on loads, then returns the sign/zero-extended result with a one-cycle `done` pulse. It consumes the main decoder's `Load[2:0]`/`Store[1:0]` encodings, and replaces the single-cycle data-memory assumption.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_controller_if.sv | 24 ++
 rtl/lsu_align.sv | 59 +++++
 rtl/lsu_controller.sv | 120 ++++++++++++
 tb/tb_lsu_controller.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and encodings for the load/store unit.
// Decoder encodings mirror the main decoder Load[2:0] / Store[1:0].
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_WAIT = 2'b10,
      S_DONE = 2'b11
   } lsu_state_t;

   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b011;
   localparam logic [2:0] LOAD_LHU = 3'b100;

   localparam logic [1:0] STORE_SW = 2'b00;
   localparam logic [1:0] STORE_SH = 2'b01;
   localparam logic [1:0] STORE_SB = 2'b10;

   // Natural-alignment check; unknown encodings behave as word accesses.
   function automatic logic f_misaligned(
      input logic       is_store,
      input logic [2:0] ld,
      input logic [1:0] st,
      input logic [1:0] off
   );
      logic r;
      r = (off != 2'b00);
      if (is_store) begin
         if (st == STORE_SH)      r = off[0];
         else if (st == STORE_SB) r = 1'b0;
      end else begin
         if (ld == LOAD_LH || ld == LOAD_LHU)      r = off[0];
         else if (ld == LOAD_LB || ld == LOAD_LBU) r = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/lsu_controller_if.sv
// lsu_controller_if: handshaked data-memory port of the LSU.
// master = LSU side, slave = memory side.
interface lsu_controller_if #(
   parameter int ADDR_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and extension for loads.
// Purely combinational; word/half offsets below natural size are ignored.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        i_is_store,
   input  logic [2:0]  i_load,
   input  logic [1:0]  i_store,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [31:0] w_shift;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_shift = i_rword >> {i_off, 3'b000};
   assign w_byte  = w_shift[7:0];
   assign w_half  = i_off[1] ? i_rword[31:16] : i_rword[15:0];

   // Store lane enables and replicated data; loads read the full word.
   always_comb begin
      o_be    = 4'b1111;
      o_wdata = 32'h0;
      if (i_is_store) begin
         unique case (i_store)
            STORE_SB: begin
               o_be    = 4'b0001 << i_off;
               o_wdata = {4{i_wdata[7:0]}};
            end
            STORE_SH: begin
               o_be    = i_off[1] ? 4'b1100 : 4'b0011;
               o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
               o_be    = 4'b1111;
               o_wdata = i_wdata;
            end
         endcase
      end
   end

   // Load extraction with sign or zero extension.
   always_comb begin
      o_rdata = i_rword;
      unique case (i_load)
         LOAD_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
         LOAD_LBU: o_rdata = {24'h0, w_byte};
         LOAD_LH:  o_rdata = {{16{w_half[15]}}, w_half};
         LOAD_LHU: o_rdata = {16'h0, w_half};
         default:  o_rdata = i_rword;
      endcase
   end

endmodule

// File: rtl/lsu_controller.sv
// lsu_controller: multi-cycle load/store sequencer with stall/done.
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module lsu_controller
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_is_store,
   input  logic [2:0]        i_load,
   input  logic [1:0]        i_store,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [31:0]       i_wdata,
   output logic              o_stall,
   output logic              o_done,
   output logic [31:0]       o_rdata,
   output logic              o_misaligned,
   lsu_controller_if.master  mem
);

   lsu_state_t        r_state;
   lsu_state_t        w_state_nxt;
   logic              r_is_store;
   logic [2:0]        r_load;
   logic [1:0]        r_store;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;
   logic              w_trap;
   logic              w_req;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [31:0]       w_ext;

`ifdef LSU_MISALIGN_TRAP_EN
   logic r_misaligned;
   assign w_trap = f_misaligned(i_is_store, i_load,
                                i_store, i_addr[1:0]);
   assign o_misaligned = r_misaligned;
`else
   assign w_trap = 1'b0;
   assign o_misaligned = 1'b0;
`endif

   lsu_align u_align (
      .i_is_store (r_is_store),
      .i_load     (r_load),
      .i_store    (r_store),
      .i_off      (r_addr[1:0]),
      .i_wdata    (r_wdata),
      .i_rword    (mem.mem_rdata),
      .o_be       (w_be),
      .o_wdata    (w_wdata),
      .o_rdata    (w_ext)
   );

   // State register; reset abandons any outstanding request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state: DONE always retires to IDLE, so start is ignored there.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (i_start) w_state_nxt = w_trap ? S_DONE : S_REQ;
         S_REQ:  if (mem.mem_ready)
                    w_state_nxt = r_is_store ? S_DONE : S_WAIT;
         S_WAIT: if (mem.mem_rvalid) w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Capture the instruction at start and the load result on rvalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_store <= 1'b0;
         r_load     <= 3'b0;
         r_store    <= 2'b0;
         r_addr     <= '0;
         r_wdata    <= 32'h0;
         r_rdata    <= 32'h0;
      end else if (r_state == S_IDLE && i_start) begin
         r_is_store <= i_is_store;
         r_load     <= i_load;
         r_store    <= i_store;
         r_addr     <= i_addr;
         r_wdata    <= i_wdata;
         r_rdata    <= 32'h0;
      end else if (r_state == S_WAIT && mem.mem_rvalid) begin
         r_rdata    <= w_ext;
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   // Trap flag travels with the instruction to its done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         r_misaligned <= 1'b0;
      else if (r_state == S_IDLE && i_start) r_misaligned <= w_trap;
   end
`endif

   assign w_req = (r_state == S_REQ);

   assign mem.mem_req   = w_req;
   assign mem.mem_we    = w_req & r_is_store;
   assign mem.mem_addr  = w_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
   assign mem.mem_be    = w_req ? w_be : 4'b0000;
   assign mem.mem_wdata = w_req ? w_wdata : 32'h0;

   assign o_stall = ((r_state == S_IDLE) & i_start) | w_req
                  | (r_state == S_WAIT);
   assign o_done  = (r_state == S_DONE);
   assign o_rdata = r_rdata;

endmodule

// File: tb/tb_lsu_controller.sv
// tb_lsu_controller: directed self-checking bench for lsu_controller.
// Inputs change at negedge; outputs are sampled 1 time unit later.
module tb_lsu_controller;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  load = 3'b0;
   logic [1:0]  store = 2'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        stall, done, misaligned;
   logic [31:0] rdata;
   int          checks = 0;
   int          failures = 0;

   lsu_controller_if #(.ADDR_W(32)) mif ();

   lsu_controller #(.ADDR_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (start),
      .i_is_store   (is_store),
      .i_load       (load),
      .i_store      (store),
      .i_addr       (addr),
      .i_wdata      (wdata),
      .o_stall      (stall),
      .o_done       (done),
      .o_rdata      (rdata),
      .o_misaligned (misaligned),
      .mem          (mif)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_min_load(input logic [2:0] ld,
                              input logic [31:0] a,
                              input logic [31:0] word);
      cyc(); start = 1; is_store = 0; load = ld; addr = a;
      mif.mem_ready = 1;
      cyc(); start = 0;
      cyc(); mif.mem_ready = 0; mif.mem_rvalid = 1;
      mif.mem_rdata = word;
      cyc(); mif.mem_rvalid = 0; #1;
   endtask

   task automatic test_reset();
      mif.mem_ready = 0; mif.mem_rvalid = 0; mif.mem_rdata = 0;
      rst_n = 0;
      cyc(); #1;
      checks++;
      if ({stall, done, misaligned, rdata, mif.mem_req, mif.mem_we,
           mif.mem_addr, mif.mem_be, mif.mem_wdata} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got stall=%0b done=%0b req=%0b be=%h rdata=%h exp all zero",
                  stall, done, mif.mem_req, mif.mem_be, rdata);
      end
      rst_n = 1;
   endtask

   task automatic test_sb();
      cyc(); start = 1; is_store = 1; store = STORE_SB;
      addr = 32'h1003; wdata = 32'hAABBCCDD; mif.mem_ready = 1; #1;
      checks++;
      if (stall !== 1'b1 || mif.mem_req !== 1'b0) begin
         failures++;
         $display("FAIL sb_c0 got stall=%0b req=%0b exp 1 0", stall, mif.mem_req);
      end
      cyc(); start = 0; #1;
      checks++;
      if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1 ||
          mif.mem_be !== 4'b1000 || mif.mem_addr !== 32'h1000 ||
          mif.mem_wdata !== 32'hDDDDDDDD) begin
         failures++;
         $display("FAIL sb_bus got req=%0b we=%0b be=%b addr=%h wd=%h exp 1 1 1000 1000 DDDDDDDD",
                  mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata);
      end
      cyc(); mif.mem_ready = 0; #1;
      checks++;
      if (done !== 1'b1 || stall !== 1'b0 || rdata !== 32'h0 ||
          mif.mem_req !== 1'b0) begin
         failures++;
         $display("FAIL sb_done got done=%0b stall=%0b rdata=%h req=%0b exp 1 0 0 0",
                  done, stall, rdata, mif.mem_req);
      end
      cyc(); #1;
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL sb_pulse got done=%0b exp 0", done);
      end
   endtask

   task automatic test_lb_delayed();
      int bad_stall = 0;
      int early_done = 0;
      cyc(); start = 1; is_store = 0; load = LOAD_LB;
      addr = 32'h2001; mif.mem_ready = 0; #1;
      if (stall !== 1'b1) bad_stall++;
      if (done !== 1'b0) early_done++;
      cyc(); start = 0; #1;
      checks++;
      if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b0 ||
          mif.mem_be !== 4'b1111 || mif.mem_addr !== 32'h2000) begin
         failures++;
         $display("FAIL lb_bus got req=%0b we=%0b be=%b addr=%h exp 1 0 1111 2000",
                  mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr);
      end
      for (int c = 2; c <= 6; c++) begin
         if (c != 2) cyc();
         else cyc();
         mif.mem_ready  = (c == 3);
         mif.mem_rvalid = (c == 6);
         mif.mem_rdata  = (c == 6) ? 32'h00008000 : 32'h0;
         #1;
         if (stall !== 1'b1) bad_stall++;
         if (done !== 1'b0) early_done++;
         if (c == 4) begin
            checks++;
            if (mif.mem_req !== 1'b0) begin
               failures++;
               $display("FAIL lb_wait_req got %0b exp 0", mif.mem_req);
            end
         end
      end
      checks++;
      if (bad_stall != 0 || early_done != 0) begin
         failures++;
         $display("FAIL lb_stall got bad_stall=%0d early_done=%0d exp 0 0",
                  bad_stall, early_done);
      end
      cyc(); mif.mem_rvalid = 0; mif.mem_rdata = 0; #1;
      checks++;
      if (done !== 1'b1 || rdata !== 32'hFFFFFF80 || stall !== 1'b0 ||
          misaligned !== 1'b0) begin
         failures++;
         $display("FAIL lb_done got done=%0b rdata=%h stall=%0b mis=%0b exp 1 FFFFFF80 0 0",
                  done, rdata, stall, misaligned);
      end
   endtask

   task automatic test_loads();
      do_min_load(LOAD_LHU, 32'h2002, 32'h80010000);
      checks++;
      if (done !== 1'b1 || rdata !== 32'h00008001) begin
         failures++;
         $display("FAIL lhu got done=%0b rdata=%h exp 1 00008001", done, rdata);
      end
      do_min_load(LOAD_LH, 32'h2002, 32'h80010000);
      checks++;
      if (done !== 1'b1 || rdata !== 32'hFFFF8001) begin
         failures++;
         $display("FAIL lh got done=%0b rdata=%h exp 1 FFFF8001", done, rdata);
      end
      do_min_load(LOAD_LBU, 32'h2001, 32'h00008000);
      checks++;
      if (done !== 1'b1 || rdata !== 32'h00000080) begin
         failures++;
         $display("FAIL lbu got done=%0b rdata=%h exp 1 00000080", done, rdata);
      end
      do_min_load(3'b111, 32'h2000, 32'h89ABCDEF);
      checks++;
      if (done !== 1'b1 || rdata !== 32'h89ABCDEF) begin
         failures++;
         $display("FAIL ld111 got done=%0b rdata=%h exp 1 89ABCDEF", done, rdata);
      end
   endtask

   task automatic test_store_lanes();
      cyc(); start = 1; is_store = 1; store = STORE_SH;
      addr = 32'h4002; wdata = 32'h12345678; mif.mem_ready = 1;
      cyc(); start = 0; #1;
      checks++;
      if (mif.mem_be !== 4'b1100 || mif.mem_wdata !== 32'h56785678 ||
          mif.mem_addr !== 32'h4000) begin
         failures++;
         $display("FAIL sh_bus got be=%b wd=%h addr=%h exp 1100 56785678 4000",
                  mif.mem_be, mif.mem_wdata, mif.mem_addr);
      end
      cyc(); #1;
      cyc(); start = 1; store = 2'b11; addr = 32'h4004;
      wdata = 32'hCAFEF00D;
      cyc(); start = 0; #1;
      checks++;
      if (mif.mem_be !== 4'b1111 || mif.mem_wdata !== 32'hCAFEF00D ||
          mif.mem_addr !== 32'h4004 || mif.mem_we !== 1'b1) begin
         failures++;
         $display("FAIL sw11_bus got be=%b wd=%h addr=%h we=%0b exp 1111 CAFEF00D 4004 1",
                  mif.mem_be, mif.mem_wdata, mif.mem_addr, mif.mem_we);
      end
      cyc(); mif.mem_ready = 0; #1;
      checks++;
      if (done !== 1'b1 || rdata !== 32'h0) begin
         failures++;
         $display("FAIL sw11_done got done=%0b rdata=%h exp 1 0", done, rdata);
      end
   endtask

   task automatic test_lw_misaligned();
      cyc(); start = 1; is_store = 0; load = LOAD_LW;
      addr = 32'h3002; mif.mem_ready = 1; #1;
      checks++;
      if (stall !== 1'b1 || mif.mem_req !== 1'b0) begin
         failures++;
         $display("FAIL lwmis_c0 got stall=%0b req=%0b exp 1 0", stall, mif.mem_req);
      end
`ifdef LSU_MISALIGN_TRAP_EN
      cyc(); start = 0; mif.mem_ready = 0; #1;
      checks++;
      if (done !== 1'b1 || misaligned !== 1'b1 || rdata !== 32'h0 ||
          mif.mem_req !== 1'b0 || stall !== 1'b0) begin
         failures++;
         $display("FAIL lwmis_trap got done=%0b mis=%0b rdata=%h req=%0b stall=%0b exp 1 1 0 0 0",
                  done, misaligned, rdata, mif.mem_req, stall);
      end
`else
      cyc(); start = 0; #1;
      checks++;
      if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h3000) begin
         failures++;
         $display("FAIL lwmis_bus got req=%0b addr=%h exp 1 3000",
                  mif.mem_req, mif.mem_addr);
      end
      cyc(); mif.mem_ready = 0; mif.mem_rvalid = 1;
      mif.mem_rdata = 32'hCAFEBABE;
      cyc(); mif.mem_rvalid = 0; #1;
      checks++;
      if (done !== 1'b1 || rdata !== 32'hCAFEBABE ||
          misaligned !== 1'b0) begin
         failures++;
         $display("FAIL lwmis_load got done=%0b rdata=%h mis=%0b exp 1 CAFEBABE 0",
                  done, rdata, misaligned);
      end
`endif
   endtask

   task automatic test_reset_mid();
      cyc(); start = 1; is_store = 0; load = LOAD_LW;
      addr = 32'h5000; mif.mem_ready = 1;
      cyc(); start = 0;
      cyc(); mif.mem_ready = 0; #1;
      checks++;
      if (mif.mem_req !== 1'b0 || stall !== 1'b1) begin
         failures++;
         $display("FAIL rst_wait got req=%0b stall=%0b exp 0 1", mif.mem_req, stall);
      end
      #1 rst_n = 0;
      #1;
      checks++;
      if (mif.mem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid got req=%0b stall=%0b done=%0b exp 0 0 0",
                  mif.mem_req, stall, done);
      end
      cyc(); rst_n = 1; mif.mem_rvalid = 1; mif.mem_rdata = 32'hDEADBEEF;
      cyc(); mif.mem_rvalid = 0; #1;
      checks++;
      if (done !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin
         failures++;
         $display("FAIL rst_idle_rvalid got done=%0b stall=%0b rdata=%h exp 0 0 0",
                  done, stall, rdata);
      end
      do_min_load(LOAD_LW, 32'h6004, 32'h11223344);
      checks++;
      if (done !== 1'b1 || rdata !== 32'h11223344) begin
         failures++;
         $display("FAIL rst_next_lw got done=%0b rdata=%h exp 1 11223344", done, rdata);
      end
   endtask

   task automatic test_back_to_back();
      int n_done = 0;
      int n_req = 0;
      cyc(); start = 1; is_store = 1; store = STORE_SW;
      addr = 32'h7000; wdata = 32'h01020304; mif.mem_ready = 1; #1;
      n_done += int'(done); n_req += int'(mif.mem_req);
      cyc(); #1;
      n_done += int'(done); n_req += int'(mif.mem_req);
      cyc(); #1;
      n_done += int'(done); n_req += int'(mif.mem_req);
      checks++;
      if (done !== 1'b1 || stall !== 1'b0) begin
         failures++;
         $display("FAIL b2b_done got done=%0b stall=%0b exp 1 0", done, stall);
      end
      checks++;
      if (n_done != 1 || n_req != 1) begin
         failures++;
         $display("FAIL b2b_first got dones=%0d reqs=%0d exp 1 1", n_done, n_req);
      end
      cyc(); #1;
      checks++;
      if (stall !== 1'b1 || mif.mem_req !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle got stall=%0b req=%0b done=%0b exp 1 0 0",
                  stall, mif.mem_req, done);
      end
      cyc(); start = 0; #1;
      n_done += int'(done); n_req += int'(mif.mem_req);
      cyc(); mif.mem_ready = 0; #1;
      n_done += int'(done); n_req += int'(mif.mem_req);
      checks++;
      if (n_done != 2 || n_req != 2) begin
         failures++;
         $display("FAIL b2b_total got dones=%0d reqs=%0d exp 2 2", n_done, n_req);
      end
   endtask

   initial begin
      test_reset();
      test_sb();
      test_lb_delayed();
      test_loads();
      test_store_lanes();
      test_lw_misaligned();
      test_reset_mid();
      test_back_to_back();
      cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
